sync_filter_bank: RTL and testbench

//   Multi-channel successor to the single-bit 2-flop synchronizer. Brings WIDTH

---
 rtl/sync_filter_bank.sv | 103 ++++++++++
 tb/tb_sync_filter_bank.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sync_filter_bank.sv
// Multi-channel input synchronizer with programmable glitch filter.
// Each channel yields a synchronized level, a filtered level and edge pulses.
module sync_filter_bank #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STAGES    = 2,
  parameter bit          NEG_FIRST = 1'b1,
  parameter int unsigned FILT_BITS = 4,
  parameter bit          RST_VAL   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     async_in,
  input  logic [FILT_BITS-1:0] filt_len,
  output logic [WIDTH-1:0]     sync_out,
  output logic [WIDTH-1:0]     filt_out,
  output logic [WIDTH-1:0]     rise,
  output logic [WIDTH-1:0]     fall
);

  localparam logic [WIDTH-1:0] IDLE = {WIDTH{RST_VAL}};

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_filter_bank: STAGES must be >= 2");
  end

  // First chain stage, optionally on the falling edge
  logic [WIDTH-1:0] st0_q;

  if (NEG_FIRST) begin : g_neg_first
    // Half-cycle first stage
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) st0_q <= IDLE;
      else        st0_q <= async_in;
    end
  end else begin : g_pos_first
    // Full-cycle first stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st0_q <= IDLE;
      else        st0_q <= async_in;
    end
  end

  // Remaining synchronizer stages
  logic [WIDTH-1:0] chain_q [STAGES-1:1];

  // Shift the chain on every rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < STAGES; k++) chain_q[k] <= IDLE;
    end else begin
      chain_q[1] <= st0_q;
      for (int k = 2; k < STAGES; k++) chain_q[k] <= chain_q[k-1];
    end
  end

  assign sync_out = chain_q[STAGES-1];

  // Filter state
  logic [FILT_BITS-1:0] cnt_q [WIDTH];
  logic [FILT_BITS-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0]     filt_q, filt_d;
  logic [WIDTH-1:0]     rise_q, rise_d;
  logic [WIDTH-1:0]     fall_q, fall_d;

  // Per-channel persistence counter; a level must hold N+1 edges
  always_comb begin
    filt_d = filt_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_out[i] != filt_q[i]) begin
        if (cnt_q[i] >= filt_len) begin
          filt_d[i] = sync_out[i];
          rise_d[i] = sync_out[i];
          fall_d[i] = ~sync_out[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Filter registers and edge pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      filt_q <= IDLE;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign filt_out = filt_q;
  assign rise     = rise_q;
  assign fall     = fall_q;

endmodule

// File: tb/tb_sync_filter_bank.sv
// Directed bench for sync_filter_bank.
// Main instance uses defaults; two extra instances cover 3-stage latency.
module tb_sync_filter_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] async_in;
  logic [3:0] filt_len;

  logic [7:0] sync_out, filt_out, rise, fall;
  logic [7:0] p_sync, p_filt, p_rise, p_fall;
  logic [7:0] n_sync, n_filt, n_rise, n_fall;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  sync_filter_bank dut (
    .clk(clk), .rst_n(rst_n), .async_in(async_in), .filt_len(filt_len),
    .sync_out(sync_out), .filt_out(filt_out), .rise(rise), .fall(fall)
  );

  sync_filter_bank #(.STAGES(3), .NEG_FIRST(1'b0)) dut_p3 (
    .clk(clk), .rst_n(rst_n), .async_in(async_in), .filt_len(filt_len),
    .sync_out(p_sync), .filt_out(p_filt), .rise(p_rise), .fall(p_fall)
  );

  sync_filter_bank #(.STAGES(3), .NEG_FIRST(1'b1)) dut_n3 (
    .clk(clk), .rst_n(rst_n), .async_in(async_in), .filt_len(filt_len),
    .sync_out(n_sync), .filt_out(n_filt), .rise(n_rise), .fall(n_fall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst_n    = 1'b0;
    async_in = 8'hFF;
    filt_len = 4'd0;
    #2;
    check("rst_sync", sync_out, 8'h00);
    check("rst_filt", filt_out, 8'h00);
    check("rst_rise", rise, 8'h00);
    check("rst_fall", fall, 8'h00);
    tick();
    tick();
    check("rst_hold_sync", sync_out, 8'h00);
    rst_n = 1'b1;
    tick();
    check("rel_sync", sync_out, 8'hFF);
    check("rel_filt0", filt_out, 8'h00);
    check("rel_rise0", rise, 8'h00);
    tick();
    check("rel_filt", filt_out, 8'hFF);
    check("rel_rise", rise, 8'hFF);
    tick();
    check("rel_rise_end", rise, 8'h00);
    check("rel_filt_hold", filt_out, 8'hFF);

    async_in = 8'hFE;
    repeat (6) tick();
    async_in = 8'hFF;
    tick();
    check("lat_p3_t1", p_sync & 8'h01, 8'h00);
    check("lat_n3_t1", n_sync & 8'h01, 8'h00);
    tick();
    check("lat_p3_t2", p_sync & 8'h01, 8'h00);
    check("lat_n3_t2", n_sync & 8'h01, 8'h01);
    tick();
    check("lat_p3_t3", p_sync & 8'h01, 8'h01);

    async_in = 8'h00;
    tick();
    tick();
    check("all_fall", fall, 8'hFF);
    check("all_low", filt_out, 8'h00);
    tick();
    check("all_fall_end", fall, 8'h00);

    filt_len = 4'd3;
    tick();
    async_in = 8'h04;
    repeat (3) tick();
    async_in = 8'h00;
    repeat (6) begin
      tick();
      check("glitch_filt", filt_out, 8'h00);
      check("glitch_rise", rise, 8'h00);
    end
    async_in = 8'h04;
    repeat (4) begin
      tick();
      check("hold_pre", filt_out, 8'h00);
    end
    async_in = 8'h00;
    tick();
    check("hold_filt", filt_out, 8'h04);
    check("hold_rise", rise, 8'h04);
    tick();
    check("hold_rise_end", rise, 8'h00);
    check("hold_filt_keep", filt_out, 8'h04);
    repeat (8) tick();
    check("ch2_back_low", filt_out, 8'h00);

    filt_len = 4'd0;
    async_in = 8'h20;
    repeat (4) tick();
    check("f5_high", filt_out, 8'h20);
    async_in = 8'h00;
    tick();
    check("f5_sync", sync_out, 8'h00);
    check("f5_filt_old", filt_out, 8'h20);
    tick();
    check("f5_filt", filt_out, 8'h00);
    check("f5_fall", fall, 8'h20);
    check("f5_rise", rise, 8'h00);
    tick();
    check("f5_fall_end", fall, 8'h00);

    filt_len = 4'd15;
    async_in = 8'h80;
    repeat (7) tick();
    check("len15_wait", filt_out, 8'h00);
    filt_len = 4'd2;
    tick();
    check("len_drop_filt", filt_out, 8'h80);
    check("len_drop_rise", rise, 8'h80);

    filt_len = 4'd3;
    async_in = 8'h90;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_filt", filt_out, 8'h00);
    check("mid_rst_sync", sync_out, 8'h00);
    check("mid_rst_rise", rise, 8'h00);
    tick();
    check("mid_rst_hold", filt_out, 8'h00);
    rst_n = 1'b1;
    repeat (4) begin
      tick();
      check("post_rst_filt", filt_out, 8'h00);
      check("post_rst_rise", rise, 8'h00);
    end
    tick();
    check("post_rst_upd", filt_out, 8'h90);
    check("post_rst_pulse", rise, 8'h90);
    tick();
    check("post_rst_end", rise, 8'h00);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
